// File: rtl/sram_arbiter_mc.sv
// sram_arbiter_mc: round-robin multi-channel controller for the external async SRAM.
// Define SRAM_ARB_CH0_PRIO_EN to give channel 0 absolute priority over the round-robin.
module sram_arbiter_mc #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                       clk_100,
  input  logic                       sys_reset_n,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_we,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_ack,
  output logic [NUM_CH-1:0]          ch_rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       busy,
  output logic [ADDR_W-1:0]          sram_addr,
  inout  wire  [DATA_W-1:0]          sram_data,
  output logic                       sram_cs,
  output logic                       sram_oe,
  output logic                       sram_we
);
  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               drive;

  logic               grant;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   ptr_adv;
  int unsigned        arb_idx;

  // First requester at or after the pointer, wrapping at NUM_CH-1.
  always_comb begin
    grant   = 1'b0;
    pick    = '0;
    arb_idx = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      arb_idx = 32'(ptr_q) + k;
      if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
      if (!grant && ch_req[arb_idx]) begin
        grant = 1'b1;
        pick  = PTR_W'(arb_idx);
      end
    end
    ptr_adv = (pick == PTR_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;
`ifdef SRAM_ARB_CH0_PRIO_EN
    if (ch_req[0]) begin
      grant   = 1'b1;
      pick    = '0;
      ptr_adv = ptr_q;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    sram_cs   = 1'b1;
    sram_oe   = 1'b1;
    sram_we   = 1'b1;
    drive     = 1'b0;
    ch_ack    = '0;
    ch_rvalid = '0;
    case (state_q)
      IDLE, RECOVER: begin
        // RECOVER keeps write data on the bus for hold time and reports reads.
        if (state_q == RECOVER) begin
          drive = we_q;
          if (!we_q) ch_rvalid[win_q] = 1'b1;
        end
        if (grant) begin
          state_d = ACCESS;
          win_d   = pick;
          we_d    = ch_we[pick];
          addr_d  = ch_addr[pick*ADDR_W +: ADDR_W];
          wdata_d = ch_wdata[pick*DATA_W +: DATA_W];
          cnt_d   = '0;
          ptr_d   = ptr_adv;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        sram_cs = 1'b0;
        sram_oe = we_q;
        sram_we = !we_q;
        drive   = we_q;
        if (cnt_q == '0) ch_ack[win_q] = 1'b1;
        if (cnt_q == 3'(WAIT_CYCLES)) begin
          state_d = RECOVER;
          if (!we_q) rdata_d = sram_data;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign sram_data = drive ? wdata_q : 'z;
  assign sram_addr = addr_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter_mc.sv
// Bench for sram_arbiter_mc: directed scenarios plus random traffic against a
// transaction-timeline model of grants, pin timing and memory contents.
module tb_sram_arbiter_mc;
  localparam int NUM_CH      = 3;
  localparam int ADDR_W      = 18;
  localparam int DATA_W      = 16;
  localparam int WAIT_CYCLES = 1;

  logic                     clk_100     = 1'b0;
  logic                     sys_reset_n = 1'b0;
  logic [NUM_CH-1:0]        ch_req      = '0;
  logic [NUM_CH-1:0]        ch_we       = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_addr     = '0;
  logic [NUM_CH*DATA_W-1:0] ch_wdata    = '0;
  logic [NUM_CH-1:0]        ch_ack, ch_rvalid;
  logic [DATA_W-1:0]        rdata;
  logic                     busy;
  logic [ADDR_W-1:0]        sram_addr;
  wire  [DATA_W-1:0]        sram_data;
  logic                     sram_cs, sram_oe, sram_we;

  always #5 clk_100 = ~clk_100;

  sram_arbiter_mc #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk_100(clk_100), .sys_reset_n(sys_reset_n),
    .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_ack(ch_ack), .ch_rvalid(ch_rvalid), .rdata(rdata), .busy(busy),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we)
  );

  // External SRAM device: 64 words, decoded on the low address bits.
  function automatic logic [15:0] init_val(input logic [5:0] a);
    return {a, a, 4'hC} ^ 16'h5A5A;
  endfunction

  logic [DATA_W-1:0] sram_mem [64];
  logic [63:0]       sram_wr = '0;
  wire  [5:0]        sram_idx = sram_addr[5:0];
  assign sram_data = (!sram_cs && !sram_oe)
                     ? (sram_wr[sram_idx] ? sram_mem[sram_idx] : init_val(sram_idx)) : 'z;
  always @(posedge clk_100)
    if (!sram_cs && !sram_we) begin
      sram_mem[sram_idx] <= sram_data;
      sram_wr[sram_idx]  <= 1'b1;
    end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction timeline, grant -> WAIT+1 access clocks -> recover.
  int               cyc = 0;
  int               m_rr = 0, m_win = 0, m_grant = -100, m_free_at = 0;
  bit               m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wd = '0, m_rexp = '0, m_rdata_last = '0;
  logic [DATA_W-1:0] mmem [logic [ADDR_W-1:0]];
  int               ack_who[$];
  int               ack_cyc[$];
  logic [ADDR_W-1:0] addr_tab [16];

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (mmem.exists(a)) return mmem[a];
    return init_val(a[5:0]);
  endfunction

  task automatic model_reset();
    m_rr = 0; m_grant = -100; m_free_at = 0; m_rdata_last = '0;
  endtask

  task automatic run_cycle(input bit drop_on_ack);
    int d, w;
    bit acc, rec;
    logic [NUM_CH-1:0] oh;
    @(posedge clk_100);
    cyc++;
    if (cyc >= m_free_at) begin
      w = -1;
`ifdef SRAM_ARB_CH0_PRIO_EN
      if (ch_req[0]) w = 0;
`endif
      for (int k = 0; k < NUM_CH; k++)
        if (w < 0 && ch_req[(m_rr + k) % NUM_CH]) w = (m_rr + k) % NUM_CH;
      if (w >= 0) begin
        m_win = w; m_we = ch_we[w];
        m_addr = ch_addr[w*ADDR_W +: ADDR_W];
        m_wd   = ch_wdata[w*DATA_W +: DATA_W];
        m_grant = cyc; m_free_at = cyc + WAIT_CYCLES + 2;
        if (m_we) mmem[m_addr] = m_wd;
        else m_rexp = model_read(m_addr);
`ifdef SRAM_ARB_CH0_PRIO_EN
        if (w != 0) m_rr = (w + 1) % NUM_CH;
`else
        m_rr = (w + 1) % NUM_CH;
`endif
      end else begin
        m_free_at = cyc + 1;
      end
    end
    @(negedge clk_100);
    d   = cyc - m_grant;
    acc = (d <= WAIT_CYCLES);
    rec = (d == WAIT_CYCLES + 1);
    oh  = NUM_CH'(1) << m_win;
    if (rec && !m_we) m_rdata_last = m_rexp;
    chk("cs",     32'(sram_cs),   32'(!acc));
    chk("oe",     32'(sram_oe),   32'(!(acc && !m_we)));
    chk("we",     32'(sram_we),   32'(!(acc && m_we)));
    chk("ack",    32'(ch_ack),    (d == 0) ? 32'(oh) : 32'd0);
    chk("rvalid", 32'(ch_rvalid), (rec && !m_we) ? 32'(oh) : 32'd0);
    chk("busy",   32'(busy),      32'(acc || rec));
    chk("rdata",  32'(rdata),     32'(m_rdata_last));
    if (acc) chk("addr", 32'(sram_addr), 32'(m_addr));
    if ((acc || rec) && m_we) chk("wdata", 32'(sram_data), 32'(m_wd));
    for (int i = 0; i < NUM_CH; i++)
      if (ch_ack[i]) begin
        ack_who.push_back(i);
        ack_cyc.push_back(cyc);
        if (drop_on_ack) ch_req[i] = 1'b0;
      end
  endtask

  task automatic set_req(input int i, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd);
    ch_req[i] = 1'b1; ch_we[i] = we;
    ch_addr[i*ADDR_W +: ADDR_W] = a;
    ch_wdata[i*DATA_W +: DATA_W] = wd;
  endtask

  task automatic do_reset();
    @(negedge clk_100);
    sys_reset_n = 1'b0; ch_req = '0;
    #1 model_reset();
    @(negedge clk_100);
    sys_reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) addr_tab[i] = {12'($urandom), 6'(i)};

    // Reset state before any clock edge.
    #1;
    chk("rst_cs",     32'(sram_cs), 32'd1);
    chk("rst_oe",     32'(sram_oe), 32'd1);
    chk("rst_we",     32'(sram_we), 32'd1);
    chk("rst_ack",    32'(ch_ack), 32'd0);
    chk("rst_rvalid", 32'(ch_rvalid), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_rdata",  32'(rdata), 32'd0);
    chk("rst_addr",   32'(sram_addr), 32'd0);
    @(negedge clk_100);
    sys_reset_n = 1'b1;
    model_reset();

    // Single write from channel 1.
    set_req(1, 1'b1, 18'h00012, 16'hA5A5);
    run_cycle(1'b1);
    chk("t2_ack", 32'(ch_ack), 32'b010);
    repeat (WAIT_CYCLES + 2) run_cycle(1'b1);
    chk("t2_idle", 32'(busy), 32'd0);

    // Read it back on channel 0.
    set_req(0, 1'b0, 18'h00012, 16'h0000);
    repeat (WAIT_CYCLES + 2) run_cycle(1'b1);
    chk("t3_rvalid", 32'(ch_rvalid), 32'b001);
    chk("t3_rdata",  32'(rdata), 32'hA5A5);
    run_cycle(1'b1);

    // All channels held requesting from pointer 0.
    do_reset();
    for (int i = 0; i < NUM_CH; i++) set_req(i, 1'b0, addr_tab[i], 16'h0);
    ack_who.delete(); ack_cyc.delete();
    repeat (6 * (WAIT_CYCLES + 2)) run_cycle(1'b0);
    ch_req = '0;
    chk("t4_count", 32'(ack_who.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      if (k < ack_who.size()) begin
`ifdef SRAM_ARB_CH0_PRIO_EN
        chk("t4_order", 32'(ack_who[k]), 32'd0);
`else
        chk("t4_order", 32'(ack_who[k]), 32'(k % 3));
`endif
        if (k > 0) chk("t4_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'(WAIT_CYCLES + 2));
      end
    repeat (WAIT_CYCLES + 3) run_cycle(1'b1);

    // Reset during the second access clock of a write.
    do_reset();
    set_req(1, 1'b1, 18'h20030, 16'h1234);
    run_cycle(1'b1);
    set_req(1, 1'b1, 18'h10031, 16'h4321);
    set_req(2, 1'b0, addr_tab[5], 16'h0);
    @(posedge clk_100);
    #2 sys_reset_n = 1'b0;
    #1;
    chk("t5_we",   32'(sram_we), 32'd1);
    chk("t5_cs",   32'(sram_cs), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk_100);
    sys_reset_n = 1'b1;
    run_cycle(1'b1);
    chk("t5_first", 32'(ch_ack), 32'b010);
    repeat (2 * (WAIT_CYCLES + 2) + 2) run_cycle(1'b1);

    // Random traffic, including re-requests in the ack cycle.
    repeat (800) begin
      run_cycle(1'b1);
      for (int i = 0; i < NUM_CH; i++)
        if (!ch_req[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom), addr_tab[$urandom_range(0, 15)], 16'($urandom));
    end
    ch_req = '0;
    repeat (WAIT_CYCLES + 3) run_cycle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
